// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo: async read, sync write.
// Ports: i_clk, i_we, i_waddr, i_wdata, i_raddr, o_rdata.
module sync_fifo_ram #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, count, flags, error pulses, rdata.
// Ports: clk, rst, wr_en/wdata, rd_en/rdata, flags, count, overflow/underflow.
module sync_fifo #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = (1 << ASIZE) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] L_DEPTH  = DEPTH[ASIZE:0];
  localparam logic [ASIZE:0] L_AFULL  = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] L_AEMPTY = AEMPTY_TH[ASIZE:0];

  generate
    if (ASIZE < 1 || AFULL_TH < 1 || AFULL_TH > DEPTH ||
        AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_param_err
      $error("sync_fifo: illegal ASIZE/AFULL_TH/AEMPTY_TH");
    end
  endgenerate

  logic [ASIZE-1:0] r_wptr;
  logic [ASIZE-1:0] r_rptr;
  logic [ASIZE:0]   r_count;
  logic [DSIZE-1:0] r_rdata;
  logic             r_ovf;
  logic             r_unf;
  logic [DSIZE-1:0] w_mem_rd;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_we;

  assign full         = (r_count == L_DEPTH);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= L_AFULL);
  assign almost_empty = (r_count <= L_AEMPTY);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

  // A read never sees a same-cycle write; when full, an
  // accepted read frees the slot for a same-cycle write.
  assign w_rd_acc = rd_en & ~empty;
  assign w_wr_acc = wr_en & (~full | w_rd_acc);
  assign w_we     = w_wr_acc & ~rst;

  sync_fifo_ram #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_ram (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_waddr(r_wptr),
    .i_wdata(wdata),
    .i_raddr(r_rptr),
    .o_rdata(w_mem_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rdata <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_ovf <= wr_en & ~w_wr_acc;
      r_unf <= rd_en & ~w_rd_acc;
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= w_mem_rd;
      end
      if (w_wr_acc & ~w_rd_acc)
        r_count <= r_count + 1'b1;
      else if (w_rd_acc & ~w_wr_acc)
        r_count <= r_count - 1'b1;
    end
  end

  assign rdata = (FWFT != 0) ? w_mem_rd : r_rdata;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo, standard and FWFT instances.
// Queue-based reference model; randomized interleaved traffic.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       s_wr = 1'b0, s_rd = 1'b0;
  logic [7:0] s_wd = 8'h00, s_rdata;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [4:0] s_count;

  logic       f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] f_wd = 8'h00, f_rdata;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] m_rdata;
  logic       m_ovf0, m_unf0, m_ovf1, m_unf1;

  always #5 clk = ~clk;

  sync_fifo #(
    .DSIZE(8), .ASIZE(4), .FWFT(0),
    .AFULL_TH(14), .AEMPTY_TH(2)
  ) u_std (
    .clk(clk), .rst(rst),
    .wr_en(s_wr), .wdata(s_wd), .rd_en(s_rd),
    .rdata(s_rdata), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo #(
    .DSIZE(8), .ASIZE(4), .FWFT(1),
    .AFULL_TH(14), .AEMPTY_TH(2)
  ) u_fw (
    .clk(clk), .rst(rst),
    .wr_en(f_wr), .wdata(f_wd), .rd_en(f_rd),
    .rdata(f_rdata), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic cyc0(input bit w, input logic [7:0] d, input bit r);
    bit racc, wacc;
    s_wr = w; s_wd = d; s_rd = r;
    racc = r && (q0.size() > 0);
    wacc = w && (q0.size() < 16 || racc);
    @(posedge clk); #1;
    if (racc) m_rdata = q0.pop_front();
    if (wacc) q0.push_back(d);
    m_ovf0 = w && !wacc;
    m_unf0 = r && !racc;
    s_wr = 1'b0; s_rd = 1'b0;
  endtask

  task automatic cyc1(input bit w, input logic [7:0] d, input bit r);
    bit racc, wacc;
    f_wr = w; f_wd = d; f_rd = r;
    racc = r && (q1.size() > 0);
    wacc = w && (q1.size() < 16 || racc);
    @(posedge clk); #1;
    if (racc) void'(q1.pop_front());
    if (wacc) q1.push_back(d);
    m_ovf1 = w && !wacc;
    m_unf1 = r && !racc;
    f_wr = 1'b0; f_rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_wr = 1'b1; s_rd = 1'b1; s_wd = 8'hEE;
    f_wr = 1'b1; f_rd = 1'b1; f_wd = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0;
    s_wr = 1'b0; s_rd = 1'b0;
    f_wr = 1'b0; f_rd = 1'b0;
    q0.delete(); q1.delete();
    m_rdata = 8'h00;
    m_ovf0 = 1'b0; m_unf0 = 1'b0;
    m_ovf1 = 1'b0; m_unf1 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({s_count, s_empty, s_full, s_ae, s_af} !== {5'd0, 4'b1010}) begin
      bad++;
      $display("FAIL reset_flags got cnt=%0d e=%b f=%b ae=%b af=%b exp 0 1 0 1 0",
               s_count, s_empty, s_full, s_ae, s_af);
    end
    total++;
    if ({s_ovf, s_unf} !== 2'b00) begin
      bad++;
      $display("FAIL reset_err got ovf=%b unf=%b exp 0 0", s_ovf, s_unf);
    end
    total++;
    if (s_rdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_rdata got %h exp 00", s_rdata);
    end
    total++;
    if ({f_count, f_empty, f_ovf, f_unf} !== {5'd0, 3'b100}) begin
      bad++;
      $display("FAIL reset_fwft got cnt=%0d e=%b o=%b u=%b exp 0 1 0 0",
               f_count, f_empty, f_ovf, f_unf);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      cyc0(1'b1, 8'(i), 1'b0);
      total++;
      if (s_count !== 5'(q0.size())) begin
        bad++;
        $display("FAIL fill_count[%0d] got %0d exp %0d", i, s_count, q0.size());
      end
      total++;
      if ({s_ae, s_af, s_full, s_empty} !==
          {q0.size() <= 2, q0.size() >= 14, q0.size() == 16, q0.size() == 0}) begin
        bad++;
        $display("FAIL fill_flags[%0d] got ae=%b af=%b f=%b e=%b n=%0d",
                 i, s_ae, s_af, s_full, s_empty, q0.size());
      end
    end
    cyc0(1'b1, 8'hFF, 1'b0);
    total++;
    if (s_ovf !== 1'b1 || s_count !== 5'd16) begin
      bad++;
      $display("FAIL fill_overflow got ovf=%b cnt=%0d exp 1 16", s_ovf, s_count);
    end
    cyc0(1'b0, 8'h00, 1'b0);
    total++;
    if (s_ovf !== 1'b0) begin
      bad++;
      $display("FAIL overflow_pulse got %b exp 0", s_ovf);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      cyc0(1'b0, 8'h00, 1'b1);
      total++;
      if (s_rdata !== m_rdata || s_count !== 5'(q0.size())) begin
        bad++;
        $display("FAIL drain[%0d] got rdata=%h cnt=%0d exp %h %0d",
                 i, s_rdata, s_count, m_rdata, q0.size());
      end
    end
    total++;
    if (s_empty !== 1'b1 || s_rdata !== 8'h0F) begin
      bad++;
      $display("FAIL drain_end got e=%b rdata=%h exp 1 0f", s_empty, s_rdata);
    end
    cyc0(1'b0, 8'h00, 1'b1);
    total++;
    if (s_unf !== 1'b1 || s_rdata !== 8'h0F) begin
      bad++;
      $display("FAIL underflow got unf=%b rdata=%h exp 1 0f", s_unf, s_rdata);
    end
    cyc0(1'b0, 8'h00, 1'b0);
    total++;
    if (s_unf !== 1'b0) begin
      bad++;
      $display("FAIL underflow_pulse got %b exp 0", s_unf);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) cyc0(1'b1, 8'($urandom_range(0, 127)), 1'b0);
    cyc0(1'b1, 8'h80, 1'b1);
    total++;
    if (s_count !== 5'd16 || s_ovf !== 1'b0 || s_rdata !== m_rdata) begin
      bad++;
      $display("FAIL full_rw got cnt=%0d ovf=%b rdata=%h exp 16 0 %h",
               s_count, s_ovf, s_rdata, m_rdata);
    end
    for (int i = 0; i < 16; i++) begin
      cyc0(1'b0, 8'h00, 1'b1);
      total++;
      if (s_rdata !== m_rdata) begin
        bad++;
        $display("FAIL full_rw_read[%0d] got %h exp %h", i, s_rdata, m_rdata);
      end
    end
    total++;
    if (s_rdata !== 8'h80 || s_empty !== 1'b1) begin
      bad++;
      $display("FAIL full_rw_last got rdata=%h e=%b exp 80 1", s_rdata, s_empty);
    end
  endtask

  task automatic test_random();
    bit w, r;
    for (int i = 0; i < 100; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      cyc0(w, 8'($urandom), r);
      total++;
      if (s_count !== 5'(q0.size()) || s_rdata !== m_rdata ||
          s_ovf !== m_ovf0 || s_unf !== m_unf0) begin
        bad++;
        $display("FAIL random[%0d] got cnt=%0d rd=%h o=%b u=%b exp %0d %h %b %b",
                 i, s_count, s_rdata, s_ovf, s_unf,
                 q0.size(), m_rdata, m_ovf0, m_unf0);
      end
      total++;
      if ({s_full, s_empty, s_af, s_ae} !==
          {q0.size() == 16, q0.size() == 0, q0.size() >= 14, q0.size() <= 2}) begin
        bad++;
        $display("FAIL random_flags[%0d] got f=%b e=%b af=%b ae=%b n=%0d",
                 i, s_full, s_empty, s_af, s_ae, q0.size());
      end
    end
  endtask

  task automatic test_fwft();
    cyc1(1'b1, 8'hA5, 1'b0);
    total++;
    if (f_empty !== 1'b0 || f_rdata !== 8'hA5) begin
      bad++;
      $display("FAIL fwft_show got e=%b rdata=%h exp 0 a5", f_empty, f_rdata);
    end
    cyc1(1'b0, 8'h00, 1'b1);
    total++;
    if (f_empty !== 1'b1) begin
      bad++;
      $display("FAIL fwft_pop got e=%b exp 1", f_empty);
    end
    for (int i = 0; i < 60; i++) begin
      cyc1($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50);
      total++;
      if (f_count !== 5'(q1.size()) || f_ovf !== m_ovf1 || f_unf !== m_unf1 ||
          (q1.size() > 0 && f_rdata !== q1[0])) begin
        bad++;
        $display("FAIL fwft_random[%0d] got cnt=%0d rd=%h o=%b u=%b exp %0d %h %b %b",
                 i, f_count, f_rdata, f_ovf, f_unf, q1.size(),
                 (q1.size() > 0) ? q1[0] : 8'h00, m_ovf1, m_unf1);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 9; i++) cyc0(1'b1, 8'(i + 8'h40), 1'b0);
    total++;
    if (s_count !== 5'd9) begin
      bad++;
      $display("FAIL mid_pre got cnt=%0d exp 9", s_count);
    end
    do_reset();
    total++;
    if (s_count !== 5'd0 || s_empty !== 1'b1 || s_ovf !== 1'b0 || s_unf !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got cnt=%0d e=%b o=%b u=%b exp 0 1 0 0",
               s_count, s_empty, s_ovf, s_unf);
    end
    cyc0(1'b1, 8'h3C, 1'b0);
    cyc0(1'b0, 8'h00, 1'b1);
    total++;
    if (s_rdata !== 8'h3C || s_empty !== 1'b1) begin
      bad++;
      $display("FAIL mid_after got rdata=%h e=%b exp 3c 1", s_rdata, s_empty);
    end
  endtask

  initial begin
    m_rdata = 8'h00;
    m_ovf0 = 1'b0; m_unf0 = 1'b0;
    m_ovf1 = 1'b0; m_unf1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_random();
    test_fwft();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the next generation of the FIFO memory block, adding pointer and flag control around the storage array. It provides full/empty and programmable almost-full/almost-empty flags, an occupancy count, overflow/underflow error pulses, and two read modes: standard (registered output) and first-word-fall-through. It sits between same-clock producer and consumer pipelines wherever the team currently needs rate decoupling without a clock crossing.

## Interface
Parameters:
- DSIZE, 8: data width in bits.
- ASIZE, 4: address width; DEPTH = 1<<ASIZE entries.
- FWFT, 0: read mode; 0 = standard (registered rdata), 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2: almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 2: almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- wr_en  in  1  write request.
- wdata  in  DSIZE  write data.
- rd_en  in  1  read/pop request.
- rdata  out  DSIZE  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ASIZE+1  occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write dropped.
- underflow  out  1  one-cycle pulse: read refused.

## Operation
- Pointers wptr/rptr are ASIZE bits wide and wrap naturally modulo DEPTH. count is a registered ASIZE+1-bit up/down counter. All flags decode combinationally from count.
- rd_acc = rd_en & ~empty. Reads never bypass a same-cycle write, so a read while empty is refused even when wr_en is high.
- wr_acc = wr_en & (~full | rd_acc). When the FIFO is full, a simultaneous read and write are both accepted.
- count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- overflow = registered (wr_en & ~wr_acc). underflow = registered (rd_en & ~rd_acc). Rejected operations change no state.
- FWFT=0: on rd_acc, rdata is loaded with mem[rptr]. rdata holds its value otherwise, including on refused reads.
- FWFT=1: rdata = mem[rptr] combinationally and is valid whenever empty=0. rd_acc pops the head. rdata is don't-care while empty.
- Memory contents are not reset. Only pointers, count, rdata, overflow and underflow are reset.
- Parameter violations (thresholds out of range, ASIZE<1) are reported with an elaboration-time error.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rdata=0 (FWFT=0), pointers=0.
- Reset mid-operation discards all contents. The cycle after rst deasserts behaves as an empty FIFO. wr_en and rd_en are ignored while rst=1 and no error pulses are raised.
- Write at edge N: count, empty and full reflect the write after edge N. In FWFT mode, rdata shows the word in that same cycle (write-to-read latency of 1 cycle).
- Standard read accepted at edge N: the new rdata is valid after edge N (1-cycle latency).
- Error pulses appear for exactly one cycle after the offending edge.
- Full-throughput streaming (wr_en=rd_en=1 with 0<count<DEPTH) sustains one word per cycle with count constant.

## Structure
- No shared package is needed. DEPTH and the parameter-check localparams stay local to sync_fifo.
- Sub-module sync_fifo_ram: DSIZE x DEPTH array with asynchronous read at raddr and synchronous write gated by we (driven by wr_acc).
- Pointer, count, flag and error logic, plus the standard-mode output register, all live in sync_fifo.

## Test plan
All scenarios use DSIZE=8, ASIZE=4, AFULL_TH=14, AEMPTY_TH=2 unless noted.
- Fill: after reset, write 0x00..0x0F on 16 consecutive cycles -> almost_empty drops after the 3rd write, almost_full rises after the 14th, full=1 and count=16 after the 16th. A 17th write -> overflow pulses once, count stays 16.
- Drain, FWFT=0: from full, rd_en for 16 cycles -> rdata reads 0x00..0x0F, each valid the cycle after accept. empty=1 after the last read. A 17th read -> underflow pulses once and rdata holds 0x0F.
- Full with simultaneous read and write, writing 0x80 -> both accepted, count stays 16, 0x80 is read out 16 reads later.
- Wrap-around: 100 random interleaved read/write cycles against a scoreboard -> data order exact, count matches the model, and no error pulses except on the modelled rejections.
- FWFT=1: write 0xA5 into an empty FIFO -> next cycle empty=0 and rdata=0xA5 with no read issued. Pop -> empty=1 the next cycle.
- Reset mid-operation: rst=1 for one cycle at count=9 -> next cycle count=0, empty=1. A subsequent write of 0x3C followed by a read returns 0x3C.
